fetch_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 13 +
 rtl/fetch_nextpc.sv | 30 +++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core.
// Contents: fetch FSM state type, datapath widths, default reset vector.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam int JIDX_W = 26;

  localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_nextpc.sv
// Next-PC selection for a retiring instruction. Purely combinational, so a
// pipelined core can reuse it as-is.
// Inputs : pcplus4, signimm (word offset), jindex, pcsrc, jump
// Output : nextpc
// Priority: jump > branch (pcsrc) > sequential.
module fetch_nextpc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pcplus4,
  input  logic [WORD_W-1:0] signimm,
  input  logic [JIDX_W-1:0] jindex,
  input  logic              pcsrc,
  input  logic              jump,
  output logic [WORD_W-1:0] nextpc
);
  logic [WORD_W-1:0] brtarget;
  logic [WORD_W-1:0] jtarget;

  // Word offset to byte offset. The top two bits of signimm fall off and the
  // sum wraps modulo 2^32 with no fault.
  assign brtarget = pcplus4 + {signimm[WORD_W-3:0], 2'b00};
  // Jump stays inside the current 256 MB region of pcplus4.
  assign jtarget  = {pcplus4[WORD_W-1:WORD_W-4], jindex, 2'b00};

  always_comb begin
    nextpc = pcplus4;
    if (jump)       nextpc = jtarget;
    else if (pcsrc) nextpc = brtarget;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Owns the PC, reads one word per instruction
// from instruction memory, holds it for decode until retire, then picks the
// next PC from the redirect inputs.
// Ports:
//   clk, reset                  clock, async active-high reset
//   imem_req/addr/ack/rdata     instruction memory handshake (ack = data now)
//   instr, instr_valid          held instruction and its valid flag
//   pc, pcplus4                 address of held instruction and pc+4
//   retire, pcsrc, jump         retire strobe and redirect selects
//   signimm, jindex             branch word offset and jump index
//   instret                     retired-instruction counter (wraps)
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC
)(
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pcplus4,
  input  logic              retire,
  input  logic              pcsrc,
  input  logic              jump,
  input  logic [WORD_W-1:0] signimm,
  input  logic [JIDX_W-1:0] jindex,
  output logic [WORD_W-1:0] instret
);
  fetch_state_t      state, state_nxt;
  logic              capture;
  logic              accept;
  logic [WORD_W-1:0] nextpc;

  fetch_nextpc u_nextpc (
    .pcplus4 (pcplus4),
    .signimm (signimm),
    .jindex  (jindex),
    .pcsrc   (pcsrc),
    .jump    (jump),
    .nextpc  (nextpc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Reset parks the FSM in FETCH, so the request is also gated by reset to
  // make it drop the moment reset rises rather than at the next edge.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = ~reset;
        if (imem_ack) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          accept    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // One PC register serves as both the fetch address and the held-instruction
  // address: it only moves on retire, so it is stable through wait states
  // and frozen during HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      pcplus4     <= RESET_PC + 32'd4;
      instr       <= '0;
      instr_valid <= 1'b0;
      instret     <= '0;
    end else begin
      if (capture) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (accept) begin
        instr_valid <= 1'b0;
        pc          <= nextpc;
        pcplus4     <= nextpc + 32'd4;
        instret     <= instret + 32'd1;
      end
    end
  end

  assign imem_addr = pc;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        retire;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;
  logic [25:0] jindex;
  logic [31:0] instret;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .retire      (retire),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .signimm     (signimm),
    .jindex      (jindex),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ack(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic do_retire(input logic br, input logic jp,
                           input logic [31:0] imm, input logic [25:0] idx);
    retire  = 1'b1;
    pcsrc   = br;
    jump    = jp;
    signimm = imm;
    jindex  = idx;
    tick();
    retire  = 1'b0;
    pcsrc   = 1'b0;
    jump    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
    retire = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = '0; jindex = '0;
    tick(); tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0 || pcplus4 !== 32'h4) begin
      failures++;
      $display("FAIL reset_pc: req=%b addr=%h pc=%h pc4=%h required 0/0/0/4", imem_req, imem_addr, pc, pcplus4);
    end
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || instret !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs: instr=%h valid=%b instret=%h required 0/0/0", instr, instr_valid, instret);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h required 1/0", imem_req, imem_addr);
    end
    tick();
    imem_ack = 1'b0;
    checks++;
    if (instr !== 32'hAAAA_0001 || instr_valid !== 1'b1 || pc !== 32'h0 || pcplus4 !== 32'h4 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL first_fetch: instr=%h valid=%b pc=%h pc4=%h req=%b required aaaa0001/1/0/4/0",
               instr, instr_valid, pc, pcplus4, imem_req);
    end
  endtask

  task automatic test_hold();
    // Ack outside FETCH and idle cycles must not disturb the held instruction.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick(); tick();
    imem_ack = 1'b0;
    checks++;
    if (instr !== 32'hAAAA_0001 || instr_valid !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0 || instret !== 32'h0) begin
      failures++;
      $display("FAIL hold_frozen: instr=%h valid=%b pc=%h req=%b instret=%h required aaaa0001/1/0/0/0",
               instr, instr_valid, pc, imem_req, instret);
    end
  endtask

  task automatic test_sequential();
    do_retire(1'b0, 1'b1, 32'h0, 26'h4);     // jump to 0x10
    checks++;
    if (imem_addr !== 32'h10 || imem_req !== 1'b1 || instr_valid !== 1'b0 || instret !== 32'd1) begin
      failures++;
      $display("FAIL jump_0x10: addr=%h req=%b valid=%b instret=%0d required 10/1/0/1",
               imem_addr, imem_req, instr_valid, instret);
    end
    fetch_ack(32'h1111_0010);
    do_retire(1'b0, 1'b0, 32'h0, 26'h0);
    checks++;
    if (imem_addr !== 32'h14 || instret !== 32'd2) begin
      failures++;
      $display("FAIL seq_next: addr=%h instret=%0d required 14/2", imem_addr, instret);
    end
  endtask

  task automatic test_branch();
    fetch_ack(32'h2222_0014);
    do_retire(1'b0, 1'b1, 32'h0, 26'h10);    // 0x40
    fetch_ack(32'h3333_0040);
    do_retire(1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0);
    checks++;
    if (imem_addr !== 32'h3C || instret !== 32'd4) begin
      failures++;
      $display("FAIL branch_back: addr=%h instret=%0d required 3c/4", imem_addr, instret);
    end
    fetch_ack(32'h4444_003C);
    do_retire(1'b1, 1'b0, 32'h23FF_FFF0, 26'h0); // 0x40 + 0x8FFFFFC0
    fetch_ack(32'h5555_0000);
    checks++;
    if (pc !== 32'h9000_0000 || pcplus4 !== 32'h9000_0004) begin
      failures++;
      $display("FAIL branch_far: pc=%h pc4=%h required 90000000/90000004", pc, pcplus4);
    end
    do_retire(1'b1, 1'b1, 32'h0000_0100, 26'h10);
    checks++;
    if (imem_addr !== 32'h9000_0040 || instret !== 32'd6) begin
      failures++;
      $display("FAIL jump_priority: addr=%h instret=%0d required 90000040/6", imem_addr, instret);
    end
  endtask

  task automatic test_wait_states();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h9000_0040 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL wait_cycle%0d: req=%b addr=%h valid=%b required 1/90000040/0",
                 c, imem_req, imem_addr, instr_valid);
      end
      // Spurious retire with a jump while still fetching.
      retire = (c == 0); jump = (c == 0); jindex = 26'h3;
      imem_ack = (c == 3); imem_rdata = 32'h6666_0040;
      tick();
    end
    retire = 1'b0; jump = 1'b0; imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h6666_0040 || pc !== 32'h9000_0040 || instret !== 32'd6) begin
      failures++;
      $display("FAIL wait_capture: valid=%b instr=%h pc=%h instret=%0d required 1/66660040/90000040/6",
               instr_valid, instr, pc, instret);
    end
  endtask

  task automatic test_wrap();
    do_retire(1'b1, 1'b0, 32'h1BFF_FFEE, 26'h0); // 0x90000044 + 0x6FFFFFB8
    fetch_ack(32'h7777_FFFC);
    checks++;
    if (pc !== 32'hFFFF_FFFC || pcplus4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pc4: pc=%h pc4=%h required fffffffc/0", pc, pcplus4);
    end
    do_retire(1'b0, 1'b0, 32'h0, 26'h0);
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1 || instret !== 32'd8) begin
      failures++;
      $display("FAIL wrap_next: addr=%h req=%b instret=%0d required 0/1/8", imem_addr, imem_req, instret);
    end
  endtask

  task automatic test_reset_mid_fetch();
    fetch_ack(32'h8888_0000);
    do_retire(1'b0, 1'b1, 32'h0, 26'h20);    // 0x80
    tick();                                   // one wait cycle, no ack
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      failures++;
      $display("FAIL pre_reset: req=%b addr=%h required 1/80", imem_req, imem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instret !== 32'h0) begin
      failures++;
      $display("FAIL reset_drop: req=%b addr=%h instret=%0d required 0/0/0", imem_req, imem_addr, instret);
    end
    tick();
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0080;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_req: req=%b addr=%h required 1/0", imem_req, imem_addr);
    end
    tick();
    imem_ack = 1'b0;
    checks++;
    if (pc !== 32'h0 || pcplus4 !== 32'h4 || instr_valid !== 1'b1 || instr !== 32'hDEAD_0080) begin
      failures++;
      $display("FAIL stale_ack: pc=%h pc4=%h valid=%b instr=%h required 0/4/1/dead0080",
               pc, pcplus4, instr_valid, instr);
    end
  endtask

  task automatic test_reset_in_hold();
    do_retire(1'b0, 1'b0, 32'h0, 26'h0);
    fetch_ack(32'h9999_0004);
    reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instret !== 32'h0 || pc !== 32'h0) begin
      failures++;
      $display("FAIL hold_reset: valid=%b instr=%h instret=%0d pc=%h required 0/0/0/0",
               instr_valid, instr, instret, pc);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_hold();
    test_sequential();
    test_branch();
    test_wait_states();
    test_wrap();
    test_reset_mid_fetch();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
